// File: rtl/cv32e40p_sleep_ctrl.sv
// Sleep entry/exit sequencer around the core clock gate, running on the free-running clock.
// Optional drain timeout is enabled by defining CV32E40P_SLEEP_DRAIN_TIMEOUT_EN.
module cv32e40p_sleep_ctrl #(
    parameter int unsigned WAKE_DELAY    = 4,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic clk_ungated_i,
    input  logic rst_i,
    input  logic sleep_req_i,
    input  logic wake_i,
    input  logic if_busy_i,
    input  logic lsu_busy_i,
    input  logic apu_busy_i,
    output logic pm_req_o,
    input  logic pm_ack_i,
    output logic clock_en_o,
    output logic core_sleep_o,
    output logic sleep_done_o,
    output logic sleep_abort_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_HSHAKE = 3'd2,
        S_SLEEP  = 3'd3,
        S_WAKE   = 3'd4
    } state_e;

    localparam int unsigned CW = (WAKE_DELAY > 0) ? $clog2(WAKE_DELAY + 1) : 1;
    localparam logic [CW-1:0] WAKE_LOAD = CW'((WAKE_DELAY > 0) ? (WAKE_DELAY - 1) : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          wrun_q, wrun_d;
    logic          done_q, done_d;
    logic          abort_d;
    logic          busy;

    assign busy = if_busy_i | lsu_busy_i | apu_busy_i;

`ifdef CV32E40P_SLEEP_DRAIN_TIMEOUT_EN
    localparam int unsigned TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);

    logic [TW-1:0] dcnt_q, dcnt_d;
    logic          abort_q;

    always_ff @(posedge clk_ungated_i or posedge rst_i) begin
        if (rst_i) begin
            dcnt_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            abort_q <= abort_d;
        end
    end

    assign sleep_abort_o = abort_q;
`else
    localparam int unsigned unused_drain_timeout = DRAIN_TIMEOUT;
    assign sleep_abort_o = 1'b0;
`endif

    always_ff @(posedge clk_ungated_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            wrun_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wrun_q  <= wrun_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wrun_d  = wrun_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
`ifdef CV32E40P_SLEEP_DRAIN_TIMEOUT_EN
        dcnt_d  = dcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sleep_req_i) begin
                    if (wake_i) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
`ifdef CV32E40P_SLEEP_DRAIN_TIMEOUT_EN
                        dcnt_d  = '0;
`endif
                    end
                end
            end
            S_DRAIN: begin
                if (wake_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (!busy) begin
                    state_d = S_HSHAKE;
                end
`ifdef CV32E40P_SLEEP_DRAIN_TIMEOUT_EN
                else if (dcnt_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    abort_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
`endif
            end
            // pm_req_o is never withdrawn before the ack, even if wake arrives first.
            S_HSHAKE: begin
                if (pm_ack_i) begin
                    state_d = wake_i ? S_WAKE : S_SLEEP;
                    wrun_d  = 1'b0;
                end
            end
            S_SLEEP: begin
                if (wake_i) begin
                    state_d = S_WAKE;
                    wrun_d  = 1'b0;
                end
            end
            // First wait for the ack to fall, then count down the settle delay.
            S_WAKE: begin
                if (!wrun_q) begin
                    if (!pm_ack_i) begin
                        if (WAKE_DELAY == 0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            wcnt_d = WAKE_LOAD;
                            wrun_d = 1'b1;
                        end
                    end
                end else if (wcnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    wrun_d  = 1'b0;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                wrun_d  = 1'b0;
            end
        endcase
    end

    assign pm_req_o     = (state_q == S_HSHAKE) || (state_q == S_SLEEP);
    assign clock_en_o   = (state_q != S_SLEEP);
    assign core_sleep_o = (state_q == S_SLEEP);
    assign sleep_done_o = done_q;

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// Bench for cv32e40p_sleep_ctrl: each sleep sequence is predicted as a timeline of event cycles.
module tb_cv32e40p_sleep_ctrl;

    localparam int WD = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sleep_req = 1'b0, wake = 1'b0, pm_ack = 1'b0;
    logic if_busy = 1'b0, lsu_busy = 1'b0, apu_busy = 1'b0;
    logic pm_req, clock_en, core_sleep, sleep_done, sleep_abort;

    int errors = 0;
    int checks = 0;
    int cur_t  = 0;

    always #5 clk = ~clk;

    cv32e40p_sleep_ctrl #(.WAKE_DELAY(WD), .DRAIN_TIMEOUT(TO)) dut (
        .clk_ungated_i (clk),
        .rst_i         (rst),
        .sleep_req_i   (sleep_req),
        .wake_i        (wake),
        .if_busy_i     (if_busy),
        .lsu_busy_i    (lsu_busy),
        .apu_busy_i    (apu_busy),
        .pm_req_o      (pm_req),
        .pm_ack_i      (pm_ack),
        .clock_en_o    (clock_en),
        .core_sleep_o  (core_sleep),
        .sleep_done_o  (sleep_done),
        .sleep_abort_o (sleep_abort)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d: observed %b expected %b", tag, cur_t, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pm_req"}, pm_req, 1'b0);
        chk({tag, "_clock_en"}, clock_en, 1'b1);
        chk({tag, "_core_sleep"}, core_sleep, 1'b0);
        chk({tag, "_done"}, sleep_done, 1'b0);
        chk({tag, "_abort"}, sleep_abort, 1'b0);
    endtask

    task automatic drive_zero();
        sleep_req = 1'b0; wake = 1'b0; pm_ack = 1'b0;
        if_busy = 1'b0; lsu_busy = 1'b0; apu_busy = 1'b0;
    endtask

    // Cycle 0 is the cycle sleep_req is raised. b: busy cycles, a: ack delay after pm_req
    // rises, tw: cycle wake is raised, r: ack drop delay after pm_req falls, rst_t: reset cycle.
    task automatic run_seq(input int b, input int a, input int tw, input int r, input int rst_t);
        int h, q, w, e, ack_on, ack_off;
        bit ab, full;
        logic [2:0] bmask;
        logic bz;
        bmask = 3'($urandom_range(1, 7));
        h = ((b > 1) ? b : 1) + 1;
        ab = 1'b0; full = 1'b0;
        q = -1; w = -1; ack_on = -1; ack_off = -1;
`ifdef CV32E40P_SLEEP_DRAIN_TIMEOUT_EN
        if (b > TO && tw > TO) begin
            ab = 1'b1;
            e  = TO + 1;
        end else
`endif
        if (tw <= h - 1) begin
            e = tw + 1;
        end else begin
            full    = 1'b1;
            q       = h + a + 1;
            w       = ((tw > h + a) ? tw : h + a) + 1;
            ack_on  = h + a;
            ack_off = w + r;
            e       = w + r + 1 + WD;
        end
        for (int t = 0; t <= e + 2; t++) begin
            cur_t = t;
            chk("pm_req", pm_req, full && t >= h && t < w);
            chk("clock_en", clock_en, !(full && t >= q && t < w));
            chk("core_sleep", core_sleep, full && t >= q && t < w);
            chk("sleep_done", sleep_done, t == e);
            chk("sleep_abort", sleep_abort, ab && t == e);
            chk("busy_during_pm", (if_busy | lsu_busy | apu_busy) & pm_req, 1'b0);
            if (t == rst_t) begin
                rst = 1'b1;
                drive_zero();
                #1;
                chk("rst_async_pm_req", pm_req, 1'b0);
                chk("rst_async_clock_en", clock_en, 1'b1);
                chk("rst_async_core_sleep", core_sleep, 1'b0);
                #2;
                rst = 1'b0;
                step();
                chk_idle("rst_release");
                return;
            end
            sleep_req = (t < e);
            bz        = (t < b) && (t < e);
            if_busy   = bz & bmask[0];
            lsu_busy  = bz & bmask[1];
            apu_busy  = bz & bmask[2];
            wake      = (t >= tw) && (t < e);
            pm_ack    = full && t >= ack_on && t < ack_off;
            step();
        end
    endtask

    initial begin
        int b, a, tw, r, h, mode;
        drive_zero();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        step();
        chk_idle("after_reset");

        run_seq(0, 2, 8, 3, -1);
        run_seq(0, 0, 0, 0, -1);
        run_seq(10, 0, 5, 0, -1);
        run_seq(20, 1, 30, 1, -1);
        run_seq(0, 1, 50, 0, 7);
        run_seq(2, 3, 3, 1, -1);
        run_seq(3, 2, 5, 0, -1);

        for (int n = 0; n < 40; n++) begin
            b    = $urandom_range(0, 12);
            a    = $urandom_range(0, 3);
            r    = $urandom_range(0, 3);
            h    = ((b > 1) ? b : 1) + 1;
            mode = $urandom_range(0, 2);
            if (mode == 0)      tw = $urandom_range(0, h - 1);
            else if (mode == 1) tw = h + $urandom_range(0, a);
            else                tw = h + a + 1 + $urandom_range(0, 5);
            run_seq(b, a, tw, r, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
